// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry circular buffer of instruction/PC pairs between IF and ID.
// Optional zero-latency empty bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_instr_i,
    input  logic [ADDR_W-1:0]            in_pc_i,
    output logic                         out_valid_o,
    output logic [DATA_W-1:0]            out_instr_o,
    output logic [ADDR_W-1:0]            out_pc_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
`endif

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty && in_valid_i && !flush_i;
        // A bypassed entry that decode takes immediately never touches storage.
        push   = in_valid_i && !full && !flush_i && !(bypass && !stall_i);
`else
        push   = in_valid_i && !full && !flush_i;
`endif
        pop   = !empty && !stall_i && !flush_i;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr_i;
            pc_mem_q[wr_ptr_q]    <= in_pc_i;
        end
    end

    always_comb begin
        in_ready_o  = !full;
        full_o      = full;
        empty_o     = empty;
        count_o     = count_q;
        out_valid_o = !empty;
        out_instr_o = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];
        out_pc_o    = empty ? '0 : pc_mem_q[rd_ptr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid_o = 1'b1;
            out_instr_o = in_instr_i;
            out_pc_o    = in_pc_i;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/backpressure, streaming wrap, flush, async reset, bypass.
// Expectations for the bypass-dependent steps follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_instr_i;
    logic [31:0] in_pc_i;
    logic        out_valid_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int errors = 0;
    int checks = 0;
    int pop_idx;

    fetch_queue dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_instr"}, 64'(out_instr_o), 64'(NOP));
        chk({tag, "_pc"},    64'(out_pc_o),    64'd0);
        chk({tag, "_count"}, 64'(count_o),     64'd0);
        chk({tag, "_empty"}, 64'(empty_o),     64'd1);
        chk({tag, "_full"},  64'(full_o),      64'd0);
        chk({tag, "_ready"}, 64'(in_ready_o),  64'd1);
    endtask

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        in_valid_i = 1'b0; in_instr_i = '0; in_pc_i = '0;

        // Reset then idle
        repeat (2) @(posedge clk_i);
        #1;
        chk_idle("in_reset");
        rst_ni = 1'b1;
        #1;
        chk_idle("after_reset");
        $display("txn reset_idle done");

        // Fill under stall, then a fifth push that must be ignored
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_pc_i = 32'(4 * i); in_instr_i = 32'h1000_0000 + 32'(4 * i);
            tick();
            $display("txn fill push pc=%0h count=%0d", in_pc_i, count_o);
        end
        chk("fill_count", 64'(count_o),    64'd4);
        chk("fill_full",  64'(full_o),     64'd1);
        chk("fill_ready", 64'(in_ready_o), 64'd0);
        chk("fill_head",  64'(out_pc_o),   64'd0);
        in_pc_i = 32'h10; in_instr_i = 32'h1000_0010;
        tick();
        chk("fifth_count", 64'(count_o),  64'd4);
        chk("fifth_head",  64'(out_pc_o), 64'd0);
        in_valid_i = 1'b0; stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 64'(out_valid_o), 64'd1);
            chk("drain_pc",    64'(out_pc_o),    64'(4 * i));
            chk("drain_instr", 64'(out_instr_o), 64'(32'h1000_0000 + 32'(4 * i)));
            $display("txn drain pop pc=%0h", out_pc_o);
            tick();
        end
        chk_idle("drained");

        // Streaming 12 entries with no stall; pointers wrap three times
        pop_idx = 0;
        for (int k = 0; k < 13; k++) begin
            in_valid_i = (k < 12);
            in_pc_i    = 32'(4 * k);
            in_instr_i = 32'h2000_0000 + 32'(4 * k);
            #1;
            if (out_valid_o) begin
                chk("stream_pc",    64'(out_pc_o),    64'(4 * pop_idx));
                chk("stream_instr", 64'(out_instr_o), 64'(32'h2000_0000 + 32'(4 * pop_idx)));
                $display("txn stream pop pc=%0h", out_pc_o);
                pop_idx++;
            end
            chk("stream_count_le1", 64'(count_o <= 3'd1), 64'd1);
            tick();
        end
        in_valid_i = 1'b0;
        chk("stream_pops", 64'(pop_idx), 64'd12);
        #1;
        chk_idle("stream_end");

        // Flush with count=3 while a push and pop are also requested
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_pc_i = 32'h200 + 32'(4 * i); in_instr_i = 32'h3000_0000 + 32'(i);
            tick();
        end
        chk("preflush_count", 64'(count_o), 64'd3);
        stall_i = 1'b0; flush_i = 1'b1; in_pc_i = 32'h20C; in_instr_i = 32'h3000_0003;
        #1;
        chk("flush_ready_ungated", 64'(in_ready_o), 64'd1);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk_idle("post_flush");
        tick();
        chk_idle("post_flush2");
        $display("txn flush done");

        // Asynchronous reset between edges with count=2
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_pc_i = 32'h300 + 32'(4 * i); in_instr_i = 32'h4000_0000 + 32'(i);
            tick();
        end
        in_valid_i = 1'b0;
        chk("prereset_count", 64'(count_o),     64'd2);
        chk("prereset_valid", 64'(out_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_idle("async_reset");
        tick();
        rst_ni = 1'b1; stall_i = 1'b0;
        #1;
        chk_idle("after_async_reset");
        $display("txn async_reset done");

        // Bypass probe: empty queue, stall low
        in_valid_i = 1'b1; in_instr_i = 32'h0050_0093; in_pc_i = 32'h100;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_same_valid", 64'(out_valid_o), 64'd1);
        chk("byp_same_instr", 64'(out_instr_o), 64'h0050_0093);
        chk("byp_same_pc",    64'(out_pc_o),    64'h100);
        chk("byp_same_count", 64'(count_o),     64'd0);
`else
        chk("byp_same_valid", 64'(out_valid_o), 64'd0);
        chk("byp_same_instr", 64'(out_instr_o), 64'(NOP));
`endif
        tick();
        in_valid_i = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk_idle("byp_next");
`else
        chk("byp_next_valid", 64'(out_valid_o), 64'd1);
        chk("byp_next_instr", 64'(out_instr_o), 64'h0050_0093);
        chk("byp_next_pc",    64'(out_pc_o),    64'h100);
        chk("byp_next_count", 64'(count_o),     64'd1);
`endif
        tick();
        chk_idle("byp_end");
        $display("txn bypass done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
